uart_rx_sim_monitor: RTL and testbench

- Simulation-top UART receiver. Sits directly downstream of the chip's UART TX pad output (dedicated I/O bit 9) in the verilator top, alongside the UART DPI.
- Deserialises 8N1 frames into bytes and buffers them in a show-ahead FIFO with a valid/ready read port.
- Flags framing errors, FIFO overflow and end-of-line so that bench logic can log console output and detect test banners without the DPI.

---
 rtl/uart_rx_sim_monitor.sv | 217 +++++++++++++++++++++
 tb/tb_uart_rx_sim_monitor.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_sim_monitor.sv
// 8N1 UART receiver for the simulation top: deserialises the chip's TX pad into a show-ahead
// byte FIFO and flags framing errors, FIFO overflow and end-of-line.
module uart_rx_sim_monitor #(
    parameter int unsigned CLK_FREQ   = 500000,
    parameter int unsigned BAUD       = 7200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             rx_i,
    input  logic                             rx_enable_i,
    output logic [7:0]                       byte_o,
    output logic                             byte_valid_o,
    input  logic                             byte_ready_i,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level_o,
    output logic                             frame_err_o,
    output logic                             overflow_o,
    input  logic                             overflow_clr_i,
    output logic                             eol_o,
    output logic                             idle_o
);

    localparam int unsigned CPB  = CLK_FREQ / BAUD;
    localparam int unsigned HALF = CPB / 2;
    localparam int unsigned CW   = $clog2(CPB);
    localparam int unsigned LW   = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PW   = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] HalfLast  = CW'(HALF - 1);
    localparam logic [CW-1:0] BitLast   = CW'(CPB - 1);
    localparam logic [LW-1:0] FullLevel = LW'(FIFO_DEPTH);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StStart = 3'd1;
    localparam logic [2:0] StData  = 3'd2;
    localparam logic [2:0] StStop  = 3'd3;
    localparam logic [2:0] StBreak = 3'd4;

    // ---------------------------------------------------------------- synchroniser
    logic rx_meta_q, rx_s_q, rx_prev_q;
    logic rx_fall;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    assign rx_fall = rx_prev_q & ~rx_s_q;

    // ---------------------------------------------------------------- frame FSM
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          push_req;
    logic          stop_bad;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        push_req = 1'b0;
        stop_bad = 1'b0;
        if (!rx_enable_i) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (rx_fall) begin
                        state_d = StStart;
                        cnt_d   = '0;
                    end
                end
                StStart: begin
                    if (cnt_q == HalfLast) begin
                        cnt_d    = '0;
                        bitcnt_d = '0;
                        // A line already back high at mid start bit was a glitch.
                        state_d  = rx_s_q ? StIdle : StData;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StData: begin
                    if (cnt_q == BitLast) begin
                        cnt_d    = '0;
                        shift_d  = {rx_s_q, shift_q[7:1]};
                        bitcnt_d = bitcnt_q + 1'b1;
                        if (bitcnt_q == 3'd7) begin
                            state_d = StStop;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StStop: begin
                    if (cnt_q == BitLast) begin
                        cnt_d = '0;
                        if (rx_s_q) begin
                            push_req = 1'b1;
                            state_d  = StIdle;
                        end else begin
                            stop_bad = 1'b1;
                            state_d  = StBreak;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StBreak: begin
                    if (rx_s_q) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            bitcnt_q <= '0;
            shift_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
        end
    end

    // ---------------------------------------------------------------- byte FIFO
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q, level_d;
    logic          full;
    logic          pop;
    logic          push_ok;
    logic          overflow_set;
    logic          overflow_q, overflow_d;
    logic          frame_err_q;
    logic          eol_q;

    assign full         = (level_q == FullLevel);
    assign byte_valid_o = (level_q != '0);
    assign pop          = byte_valid_o & byte_ready_i;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign push_ok      = push_req & (~full | pop);
    assign overflow_set = push_req & full & ~pop;

    always_comb begin
        level_d = level_q;
        if (push_ok && !pop) begin
            level_d = level_q + 1'b1;
        end else if (!push_ok && pop) begin
            level_d = level_q - 1'b1;
        end
    end

    always_comb begin
        overflow_d = overflow_q;
        if (overflow_clr_i) begin
            overflow_d = 1'b0;
        end
        if (overflow_set) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
            eol_q       <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            frame_err_q <= stop_bad;
            eol_q       <= push_ok & (shift_q == 8'h0A);
        end
    end

    // Storage is not reset, so the head is masked while empty.
    assign byte_o       = byte_valid_o ? mem_q[rd_ptr_q] : 8'h00;
    assign fifo_level_o = level_q;
    assign frame_err_o  = frame_err_q;
    assign overflow_o   = overflow_q;
    assign eol_o        = eol_q;
    assign idle_o       = (state_q == StIdle);

endmodule

// File: tb/tb_uart_rx_sim_monitor.sv
// Self-checking bench for uart_rx_sim_monitor: table of single frames, directed corner
// sequences and a randomized byte stream checked against a queue-based reference model.
module tb_uart_rx_sim_monitor;

    localparam int unsigned CPB = 500000 / 7200;
    // Posedges from driving the start bit to byte_valid_o being visible.
    localparam int unsigned LAT = 658;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       rx_i;
    logic       rx_enable_i;
    logic [7:0] byte_o;
    logic       byte_valid_o;
    logic       byte_ready_i;
    logic [4:0] fifo_level_o;
    logic       frame_err_o;
    logic       overflow_o;
    logic       overflow_clr_i;
    logic       eol_o;
    logic       idle_o;

    uart_rx_sim_monitor dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .rx_i           (rx_i),
        .rx_enable_i    (rx_enable_i),
        .byte_o         (byte_o),
        .byte_valid_o   (byte_valid_o),
        .byte_ready_i   (byte_ready_i),
        .fifo_level_o   (fifo_level_o),
        .frame_err_o    (frame_err_o),
        .overflow_o     (overflow_o),
        .overflow_clr_i (overflow_clr_i),
        .eol_o          (eol_o),
        .idle_o         (idle_o)
    );

    always #5 clk_i = ~clk_i;

    // Passive monitor: counts pulses and records every popped byte.
    int         n_err_seen = 0;
    int         n_eol_seen = 0;
    logic [7:0] popped[$];

    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (frame_err_o) n_err_seen++;
            if (eol_o) n_eol_seen++;
            if (byte_valid_o && byte_ready_i) popped.push_back(byte_o);
        end
    end

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // Called just after a posedge; returns just after a posedge with the stop level held.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_i = bits[i];
            wait_cyc(CPB);
        end
    endtask

    task automatic drain();
        byte_ready_i = 1'b1;
        wait_cyc(20);
        byte_ready_i = 1'b0;
    endtask

    function automatic logic [31:0] popped_at(input int idx);
        if (idx < popped.size()) return 32'(popped[idx]);
        return 32'hFFFF_FFFF;
    endfunction

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_level;
        logic [7:0] exp_head;
        int         exp_err;
        int         exp_eol;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int         base_err;
        int         base_eol;
        int         base_pop;
        int         exp_err;
        int         exp_eol;
        bit         rnd_done;
        logic [7:0] exp_q[$];
        logic [7:0] okl[3];

        vecs[0] = '{data: 8'h55, stop: 1'b1, exp_level: 1, exp_head: 8'h55, exp_err: 0, exp_eol: 0};
        vecs[1] = '{data: 8'h00, stop: 1'b1, exp_level: 1, exp_head: 8'h00, exp_err: 0, exp_eol: 0};
        vecs[2] = '{data: 8'hFF, stop: 1'b1, exp_level: 1, exp_head: 8'hFF, exp_err: 0, exp_eol: 0};
        vecs[3] = '{data: 8'h0A, stop: 1'b1, exp_level: 1, exp_head: 8'h0A, exp_err: 0, exp_eol: 1};
        vecs[4] = '{data: 8'hC3, stop: 1'b0, exp_level: 0, exp_head: 8'h00, exp_err: 1, exp_eol: 0};
        vecs[5] = '{data: 8'h81, stop: 1'b1, exp_level: 1, exp_head: 8'h81, exp_err: 0, exp_eol: 0};

        rst_i          = 1'b1;
        rx_i           = 1'b1;
        rx_enable_i    = 1'b1;
        byte_ready_i   = 1'b0;
        overflow_clr_i = 1'b0;
        wait_cyc(3);
        rst_i = 1'b0;
        wait_cyc(2);

        // Reset state
        check("rst byte_o", 32'(byte_o), 32'h0);
        check("rst valid", 32'(byte_valid_o), 32'h0);
        check("rst level", 32'(fifo_level_o), 32'h0);
        check("rst frame_err", 32'(frame_err_o), 32'h0);
        check("rst overflow", 32'(overflow_o), 32'h0);
        check("rst eol", 32'(eol_o), 32'h0);
        check("rst idle", 32'(idle_o), 32'h1);

        // Latency of 0x55 into an empty FIFO
        base_err = n_err_seen;
        fork
            send_frame(8'h55, 1'b1);
            begin
                wait_cyc(LAT - 1);
                check("lat valid early", 32'(byte_valid_o), 32'h0);
                wait_cyc(1);
                check("lat valid", 32'(byte_valid_o), 32'h1);
                check("lat byte", 32'(byte_o), 32'h55);
                check("lat level", 32'(fifo_level_o), 32'h1);
            end
        join
        check("lat no frame_err", 32'(n_err_seen - base_err), 32'h0);
        drain();

        // Table of single frames into an empty FIFO
        foreach (vecs[i]) begin
            drain();
            base_err = n_err_seen;
            base_eol = n_eol_seen;
            send_frame(vecs[i].data, vecs[i].stop);
            if (!vecs[i].stop) wait_cyc(50);
            rx_i = 1'b1;
            wait_cyc(20);
            check($sformatf("vec%0d level", i), 32'(fifo_level_o), 32'(vecs[i].exp_level));
            check($sformatf("vec%0d head", i), 32'(byte_o), 32'(vecs[i].exp_head));
            check($sformatf("vec%0d err", i), 32'(n_err_seen - base_err), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d eol", i), 32'(n_eol_seen - base_eol), 32'(vecs[i].exp_eol));
            check($sformatf("vec%0d idle", i), 32'(idle_o), 32'h1);
        end
        drain();

        // "OK\n" back-to-back, then pop three
        okl[0] = 8'h4F;
        okl[1] = 8'h4B;
        okl[2] = 8'h0A;
        base_eol = n_eol_seen;
        base_pop = popped.size();
        send_frame(okl[0], 1'b1);
        send_frame(okl[1], 1'b1);
        check("ok eol before lf", 32'(n_eol_seen - base_eol), 32'h0);
        send_frame(okl[2], 1'b1);
        wait_cyc(2);
        check("ok eol after lf", 32'(n_eol_seen - base_eol), 32'h1);
        check("ok level 3", 32'(fifo_level_o), 32'h3);
        byte_ready_i = 1'b1;
        wait_cyc(5);
        byte_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("ok pop%0d", i), popped_at(base_pop + i), 32'(okl[i]));
        end
        check("ok pop count", 32'(popped.size() - base_pop), 32'h3);
        check("ok level 0", 32'(fifo_level_o), 32'h0);
        check("ok eol total", 32'(n_eol_seen - base_eol), 32'h1);

        // 20-cycle glitch, then 0xA3
        rx_i = 1'b0;
        wait_cyc(20);
        rx_i = 1'b1;
        wait_cyc(60);
        check("glitch idle", 32'(idle_o), 32'h1);
        check("glitch level", 32'(fifo_level_o), 32'h0);
        send_frame(8'hA3, 1'b1);
        wait_cyc(5);
        check("glitch A3 level", 32'(fifo_level_o), 32'h1);
        check("glitch A3 byte", 32'(byte_o), 32'hA3);
        drain();

        // Bad stop bit with the line held low, then a good frame
        base_err = n_err_seen;
        send_frame(8'h3C, 1'b0);
        wait_cyc(300);
        check("break err", 32'(n_err_seen - base_err), 32'h1);
        check("break level", 32'(fifo_level_o), 32'h0);
        check("break not idle", 32'(idle_o), 32'h0);
        rx_i = 1'b1;
        wait_cyc(10);
        check("break released idle", 32'(idle_o), 32'h1);
        send_frame(8'h3C, 1'b1);
        wait_cyc(5);
        check("break 3C byte", 32'(byte_o), 32'h3C);
        check("break 3C level", 32'(fifo_level_o), 32'h1);
        check("break err total", 32'(n_err_seen - base_err), 32'h1);
        drain();

        // Overflow: 17 bytes with no reader
        for (int b = 0; b < 17; b++) send_frame(8'(b), 1'b1);
        wait_cyc(5);
        check("ovf level", 32'(fifo_level_o), 32'd16);
        check("ovf flag", 32'(overflow_o), 32'h1);
        check("ovf head", 32'(byte_o), 32'h00);
        overflow_clr_i = 1'b1;
        wait_cyc(1);
        overflow_clr_i = 1'b0;
        check("ovf cleared", 32'(overflow_o), 32'h0);
        drain();
        check("ovf drained", 32'(fifo_level_o), 32'h0);

        // Same again with a pop in the cycle of the 17th push
        for (int b = 0; b < 16; b++) send_frame(8'(b), 1'b1);
        fork
            send_frame(8'h10, 1'b1);
            begin
                wait_cyc(LAT - 1);
                byte_ready_i = 1'b1;
                wait_cyc(1);
                byte_ready_i = 1'b0;
            end
        join
        wait_cyc(5);
        check("full+pop overflow", 32'(overflow_o), 32'h0);
        check("full+pop head", 32'(byte_o), 32'h01);
        check("full+pop level", 32'(fifo_level_o), 32'd16);
        drain();

        // Receiver disabled mid-DATA of 0x7E
        fork
            send_frame(8'h7E, 1'b1);
            begin
                wait_cyc(200);
                rx_enable_i = 1'b0;
                wait_cyc(1);
                check("dis idle", 32'(idle_o), 32'h1);
            end
        join
        wait_cyc(5);
        check("dis level", 32'(fifo_level_o), 32'h0);
        rx_enable_i = 1'b1;
        wait_cyc(5);
        send_frame(8'h7E, 1'b1);
        wait_cyc(5);
        check("reen byte", 32'(byte_o), 32'h7E);
        check("reen level", 32'(fifo_level_o), 32'h1);
        drain();

        // Randomized stream against the queue model
        base_err = n_err_seen;
        base_eol = n_eol_seen;
        base_pop = popped.size();
        exp_err  = 0;
        exp_eol  = 0;
        rnd_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 16; k++) begin
                    logic [7:0] d;
                    logic       good;
                    d    = (k % 5 == 2) ? 8'h0A : 8'($urandom);
                    good = ($urandom_range(0, 5) != 0);
                    send_frame(d, good);
                    if (good) begin
                        exp_q.push_back(d);
                        if (d == 8'h0A) exp_eol++;
                        wait_cyc($urandom_range(0, 30));
                    end else begin
                        exp_err++;
                        wait_cyc($urandom_range(10, 200));
                        rx_i = 1'b1;
                        wait_cyc($urandom_range(5, 30));
                    end
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    byte_ready_i = ($urandom_range(0, 3) != 0);
                    wait_cyc(1);
                end
            end
        join
        drain();
        wait_cyc(5);
        check("rnd pop count", 32'(popped.size() - base_pop), 32'(exp_q.size()));
        foreach (exp_q[i]) begin
            check($sformatf("rnd pop%0d", i), popped_at(base_pop + i), 32'(exp_q[i]));
        end
        check("rnd frame_err", 32'(n_err_seen - base_err), 32'(exp_err));
        check("rnd eol", 32'(n_eol_seen - base_eol), 32'(exp_eol));
        check("rnd overflow", 32'(overflow_o), 32'h0);
        check("rnd level", 32'(fifo_level_o), 32'h0);

        // Asynchronous reset with three bytes queued
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        send_frame(8'h33, 1'b1);
        wait_cyc(2);
        check("pre-rst level", 32'(fifo_level_o), 32'h3);
        rst_i = 1'b1;
        #2;
        check("async rst level", 32'(fifo_level_o), 32'h0);
        check("async rst valid", 32'(byte_valid_o), 32'h0);
        check("async rst byte", 32'(byte_o), 32'h0);
        check("async rst idle", 32'(idle_o), 32'h1);
        check("async rst overflow", 32'(overflow_o), 32'h0);
        check("async rst frame_err", 32'(frame_err_o), 32'h0);
        check("async rst eol", 32'(eol_o), 32'h0);
        wait_cyc(2);
        rst_i = 1'b0;
        wait_cyc(2);
        check("post-rst level", 32'(fifo_level_o), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
